// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding memory request, a single-entry
// output register, and redirect handling that drops a stale in-flight response.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        pc_update_control,
  input  logic [31:0] pc_update_val,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data
);

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic        r_drop;
  logic        r_inst_valid;
  logic [31:0] r_inst_pc;
  logic [31:0] r_inst_data;

  logic        w_req_valid;
  logic        w_req_fire;
  logic [31:0] w_redirect_pc;

  // Request only when the output slot will be free next cycle; the reset term
  // keeps the request low combinationally while reset is held.
  assign w_req_valid   = i_rst && (r_state == S_REQ) && (!r_inst_valid || inst_ready)
                         && !pc_update_control;
  assign w_req_fire    = w_req_valid && imem_req_ready;
  assign w_redirect_pc = pc_update_val & 32'hFFFF_FFFC;

  assign imem_req_valid = w_req_valid;
  assign imem_addr      = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst_pc        = r_inst_pc;
  assign inst_data      = r_inst_data;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_pc    <= '0;
      r_inst_data  <= '0;
    end else if (pc_update_control) begin
      r_pc         <= w_redirect_pc;
      r_inst_valid <= 1'b0;
      // A response arriving with the redirect is discarded here; otherwise the
      // in-flight one is marked to be dropped when it arrives.
      if (r_state == S_WAIT) begin
        if (imem_rsp_valid) begin
          r_state <= S_REQ;
          r_drop  <= 1'b0;
        end else begin
          r_drop  <= 1'b1;
        end
      end
    end else begin
      if (r_inst_valid && inst_ready) begin
        r_inst_valid <= 1'b0;
      end
      if (r_state == S_REQ) begin
        if (w_req_fire) begin
          r_state <= S_WAIT;
          r_pc    <= r_pc + 32'd4;
        end
      end else begin
        if (imem_rsp_valid) begin
          r_state <= S_REQ;
          if (r_drop) begin
            r_drop <= 1'b0;
          end else begin
            r_inst_valid <= 1'b1;
            r_inst_pc    <= r_pc - 32'd4;
            r_inst_data  <= imem_rsp_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: a cycle table of directed scenarios, reset/stray-response
// sequences, then random traffic checked against a program-order model.
module tb_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        puc;
  logic [31:0] pval;
  logic        rr;
  logic        rsv;
  logic [31:0] rsd;
  logic        ir;
  logic        rv;
  logic [31:0] addr;
  logic        iv;
  logic [31:0] ipc;
  logic [31:0] idat;

  fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .pc_update_control (puc),
    .pc_update_val     (pval),
    .imem_req_valid    (rv),
    .imem_req_ready    (rr),
    .imem_addr         (addr),
    .imem_rsp_valid    (rsv),
    .imem_rsp_data     (rsd),
    .inst_valid        (iv),
    .inst_ready        (ir),
    .inst_pc           (ipc),
    .inst_data         (idat)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        puc;
    logic [31:0] pval;
    logic        rr;
    logic        rs;
    logic [31:0] rd;
    logic        ir;
    logic        erv;
    logic [31:0] ea;
    logic        eiv;
    logic [31:0] ep;
    logic [31:0] ed;
  } vec_t;

  vec_t vq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mdat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic p, input logic [31:0] pv, input logic r, input logic s,
                     input logic [31:0] d, input logic i, input logic erv, input logic [31:0] ea,
                     input logic eiv, input logic [31:0] ep, input logic [31:0] ed);
    vec_t v;
    v.puc = p; v.pval = pv; v.rr = r; v.rs = s; v.rd = d; v.ir = i;
    v.erv = erv; v.ea = ea; v.eiv = eiv; v.ep = ep; v.ed = ed;
    vq.push_back(v);
  endtask

  task automatic drive_idle();
    puc = 1'b0; pval = '0; rr = 1'b0; rsv = 1'b0; rsd = '0; ir = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic erv, input logic [31:0] ea,
                         input logic eiv, input logic [31:0] ep, input logic [31:0] ed);
    chk({tag, ".req_valid"}, 32'(rv), 32'(erv));
    chk({tag, ".addr"}, addr, ea);
    chk({tag, ".inst_valid"}, 32'(iv), 32'(eiv));
    chk({tag, ".inst_pc"}, ipc, ep);
    chk({tag, ".inst_data"}, idat, ed);
  endtask

  logic        pend, hs_prev, rsp_prev, hold_prev;
  logic [31:0] pend_addr, addr_prev, exp_pc, prev_pc, prev_dat;
  int          pend_dly;
  int          n_cons;

  initial begin
    drive_idle();
    rr = 1'b1; ir = 1'b1;
    #2 i_rst = 1'b0;

    // Straight-line fetch, decode stall at 0x4, memory stall at 0x8.
    add(0,0, 1,0,0, 1, 1,32'h0, 0,32'h0,32'h0);
    add(0,0, 1,1,mdat(32'h0), 1, 0,32'h4, 0,32'h0,32'h0);
    add(0,0, 1,0,0, 1, 1,32'h4, 1,32'h0,mdat(32'h0));
    add(0,0, 1,1,mdat(32'h4), 1, 0,32'h8, 0,32'h0,mdat(32'h0));
    for (int unsigned k = 0; k < 4; k++) add(0,0, 1,0,0, 0, 0,32'h8, 1,32'h4,mdat(32'h4));
    add(0,0, 0,0,0, 1, 1,32'h8, 1,32'h4,mdat(32'h4));
    add(0,0, 0,0,0, 1, 1,32'h8, 0,32'h4,mdat(32'h4));
    add(0,0, 0,0,0, 1, 1,32'h8, 0,32'h4,mdat(32'h4));
    add(0,0, 1,0,0, 1, 1,32'h8, 0,32'h4,mdat(32'h4));
    add(0,0, 1,1,mdat(32'h8), 1, 0,32'hC, 0,32'h4,mdat(32'h4));
    add(0,0, 1,0,0, 1, 1,32'hC, 1,32'h8,mdat(32'h8));
    add(0,0, 1,1,mdat(32'hC), 1, 0,32'h10, 0,32'h8,mdat(32'h8));
    add(0,0, 1,0,0, 1, 1,32'h10, 1,32'hC,mdat(32'hC));
    // Redirect to 0x100 while waiting on 0x10; the 0x10 response is dropped.
    add(1,32'h100, 1,0,0, 1, 0,32'h14, 0,32'hC,mdat(32'hC));
    add(0,0, 1,1,mdat(32'h10), 1, 0,32'h100, 0,32'hC,mdat(32'hC));
    add(0,0, 1,0,0, 1, 1,32'h100, 0,32'hC,mdat(32'hC));
    add(0,0, 1,1,mdat(32'h100), 1, 0,32'h104, 0,32'hC,mdat(32'hC));
    // Redirect to 0x203 with a held instruction and a coincident (stray) response.
    add(0,0, 1,0,0, 0, 0,32'h104, 1,32'h100,mdat(32'h100));
    add(1,32'h203, 1,1,32'hDEAD_BEEF, 0, 0,32'h104, 1,32'h100,mdat(32'h100));
    add(0,0, 0,0,0, 0, 1,32'h200, 0,32'h100,mdat(32'h100));
    add(0,0, 1,0,0, 1, 1,32'h200, 0,32'h100,mdat(32'h100));
    // Redirect coincident with a real response, then wrap at 0xFFFF_FFFC.
    add(1,32'hFFFF_FFFE, 1,1,mdat(32'h200), 1, 0,32'h204, 0,32'h100,mdat(32'h100));
    add(0,0, 1,0,0, 1, 1,32'hFFFF_FFFC, 0,32'h100,mdat(32'h100));
    add(0,0, 1,1,mdat(32'hFFFF_FFFC), 1, 0,32'h0, 0,32'h100,mdat(32'h100));
    add(0,0, 1,0,0, 1, 1,32'h0, 1,32'hFFFF_FFFC,mdat(32'hFFFF_FFFC));
    // Two redirects while a drop is pending: exactly one response discarded.
    add(1,32'h300, 1,0,0, 1, 0,32'h4, 0,32'hFFFF_FFFC,mdat(32'hFFFF_FFFC));
    add(1,32'h404, 1,0,0, 1, 0,32'h300, 0,32'hFFFF_FFFC,mdat(32'hFFFF_FFFC));
    add(0,0, 1,1,mdat(32'h0), 1, 0,32'h404, 0,32'hFFFF_FFFC,mdat(32'hFFFF_FFFC));
    add(0,0, 1,0,0, 1, 1,32'h404, 0,32'hFFFF_FFFC,mdat(32'hFFFF_FFFC));
    add(0,0, 1,1,mdat(32'h404), 1, 0,32'h408, 0,32'hFFFF_FFFC,mdat(32'hFFFF_FFFC));
    add(0,0, 1,0,0, 1, 1,32'h408, 1,32'h404,mdat(32'h404));

    @(negedge i_clk);
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge i_clk);

    for (int unsigned i = 0; i < vq.size(); i++) begin
      @(posedge i_clk); #1;
      if (i == 0) i_rst = 1'b1;
      puc = vq[i].puc; pval = vq[i].pval; rr = vq[i].rr;
      rsv = vq[i].rs; rsd = vq[i].rd; ir = vq[i].ir;
      @(negedge i_clk);
      chk_out($sformatf("vec%0d", i), vq[i].erv, vq[i].ea, vq[i].eiv, vq[i].ep, vq[i].ed);
    end

    // Reset in the middle of WAIT (last row's request was accepted).
    @(posedge i_clk); #1;
    i_rst = 1'b0; puc = 1'b0; rr = 1'b1; ir = 1'b1; rsv = 1'b1; rsd = 32'h1234_5678;
    @(negedge i_clk);
    chk_out("midwait_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b1; rsv = 1'b0; rr = 1'b0;
    @(negedge i_clk);
    chk_out("post_reset_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    // A response while in REQ is ignored.
    @(posedge i_clk); #1;
    rsv = 1'b1; rsd = 32'hCAFE_F00D;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    rsv = 1'b0;
    @(negedge i_clk);
    chk_out("stray_rsp", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Random traffic: consumed instructions must follow program order from
    // reset or from the most recent redirect target.
    @(posedge i_clk); #1;
    i_rst = 1'b0; drive_idle();
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    pend = 1'b0; hs_prev = 1'b0; rsp_prev = 1'b0; hold_prev = 1'b0;
    pend_addr = '0; addr_prev = '0; exp_pc = 32'h0; prev_pc = '0; prev_dat = '0;
    pend_dly = 0; n_cons = 0;
    for (int unsigned c = 0; c < 4000; c++) begin
      if (c != 0) begin
        @(posedge i_clk); #1;
      end
      if (rsp_prev) pend = 1'b0;
      if (hs_prev) begin
        chk("one_outstanding", 32'(pend), 32'h0);
        pend = 1'b1; pend_addr = addr_prev; pend_dly = int'($urandom_range(0, 3));
      end
      rr   = ($urandom_range(0, 3) != 0);
      ir   = ($urandom_range(0, 9) < 7);
      puc  = ($urandom_range(0, 15) == 0);
      pval = $urandom;
      if (pend && pend_dly == 0) begin
        rsv = 1'b1; rsd = mdat(pend_addr);
      end else begin
        rsv = 1'b0; rsd = $urandom;
        if (pend) pend_dly--;
      end
      @(negedge i_clk);
      chk("addr_align", 32'(addr[1:0]), 32'h0);
      if (puc) chk("redirect_no_req", 32'(rv), 32'h0);
      if (hold_prev) begin
        chk("hold_valid", 32'(iv), 32'h1);
        chk("hold_pc", ipc, prev_pc);
        chk("hold_data", idat, prev_dat);
      end
      if (iv && ir && !puc) begin
        chk("seq_pc", ipc, exp_pc);
        chk("seq_data", idat, mdat(ipc));
        exp_pc = exp_pc + 32'd4;
        n_cons++;
      end
      if (puc) exp_pc = pval & 32'hFFFF_FFFC;
      hold_prev = iv && !ir && !puc;
      prev_pc   = ipc;
      prev_dat  = idat;
      hs_prev   = rv && rr;
      addr_prev = addr;
      rsp_prev  = rsv;
    end
    chk("liveness", 32'(n_cons >= 50), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset.
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-low.
REQ-004 pc_update_control  input  1  redirect request from the branch stage, valid for one cycle.
REQ-005 pc_update_val  input  32  redirect target address.
REQ-006 imem_req_valid  output  1  instruction-memory request valid.
REQ-007 imem_req_ready  input  1  instruction memory accepts the request this cycle.
REQ-008 imem_addr  output  32  request address, word aligned.
REQ-009 imem_rsp_valid  input  1  read data valid, one pulse per accepted request, in order.
REQ-010 imem_rsp_data  input  32  instruction word.
REQ-011 inst_valid  output  1  fetched instruction available to decode.
REQ-012 inst_ready  input  1  decode consumes the instruction this cycle.
REQ-013 inst_pc  output  32  address of the presented instruction.
REQ-014 inst_data  output  32  presented instruction word.

Function
REQ-015 The block SHALL hold a PC register, a single-entry output register (inst_valid/inst_pc/inst_data), a drop flag and an FSM with states REQ and WAIT.
REQ-016 The block SHALL allow at most one outstanding memory request.
REQ-017 REQ: imem_req_valid SHALL equal (~inst_valid | inst_ready) & ~pc_update_control, and imem_addr SHALL equal PC.
REQ-018 REQ: a handshake (imem_req_valid & imem_req_ready) SHALL move the FSM to WAIT and PC to PC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-019 WAIT: imem_req_valid SHALL be 0; imem_rsp_valid with drop=0 SHALL load inst_pc=PC-4 and inst_data=imem_rsp_data, set inst_valid next cycle, and return to REQ.
REQ-020 WAIT: imem_rsp_valid with drop=1 SHALL discard the data, clear drop, return to REQ, and leave the output register unchanged.
REQ-021 imem_rsp_valid in REQ SHALL be ignored.
REQ-022 While inst_valid=1 and inst_ready=0, inst_pc and inst_data SHALL stay stable; inst_valid & inst_ready with no new load SHALL clear inst_valid next cycle.
REQ-023 Redirect (pc_update_control=1) SHALL take priority over every other event: PC <= {pc_update_val[31:2],2'b00}; inst_valid <= 0 regardless of inst_ready.
REQ-024 Redirect while in WAIT and no response this cycle SHALL set drop=1 and stay in WAIT.
REQ-025 Redirect in the same cycle as a response SHALL discard that response and go to REQ with drop=0.
REQ-026 Redirect in REQ SHALL issue no request that cycle and stay in REQ; the next request uses the new PC.
REQ-027 A second redirect while drop=1 SHALL overwrite PC only; drop stays 1; exactly one response is discarded.
REQ-028 The low two bits of pc_update_val SHALL be ignored; no misalignment exception is raised.
REQ-029 Best case: one instruction per 2 cycles with zero-wait memory; request-accept to inst_valid SHALL be response cycle + 1.

Reset
REQ-030 When i_rst=0: PC=RESET_PC, FSM=REQ, drop=0, inst_valid=0, inst_pc=0, inst_data=0; imem_req_valid=0 combinationally while reset is asserted.
REQ-031 The first request, with imem_addr=RESET_PC, SHALL be asserted in the first cycle after i_rst rises.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding request; instruction memory shares i_rst and SHALL not return its response.

Verification
REQ-033 Reset release, memory always ready with 1-cycle response, inst_ready=1 -> inst_pc sequence 0x0,0x4,0x8 with matching data, inst_valid every second cycle.
REQ-034 imem_req_ready low 3 cycles at addr 0x8 -> imem_req_valid and imem_addr=0x8 held stable; PC advances only after the accept.
REQ-035 inst_ready=0 for 4 cycles with inst_valid=1 at pc 0x4 -> output stable, no new request issued, fetch resumes at 0x8 after consumption.
REQ-036 Redirect to 0x100 while in WAIT for 0x10 -> response for 0x10 dropped, next inst_pc=0x100, 0x10 never presented.
REQ-037 Redirect to 0x203 coincident with a response, with inst_valid=1 and inst_ready=0 -> both instructions discarded, next imem_addr=0x200.
REQ-038 PC=0xFFFF_FFFC fetched -> next imem_addr=0x0.
